// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, sum/c_out = a + b + c_in.
// One operand bit pair is added per clock through the 1-bit full adder
// fa_v1, LSB first. The result is published as a whole on the edge that
// finishes the last bit, so sum/c_out never show partial results.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   start  in   begin an addition (sampled only in IDLE)
//   a, b   in   N-bit operands, captured on the accepting edge
//   c_in   in   carry-in, captured on the accepting edge
//   sum    out  registered N-bit result (modulo 2^N)
//   c_out  out  registered carry out of bit N-1
//   busy   out  high while state is RUN
//   done   out  one-cycle pulse while state is DONE

// fa_v1: 1-bit full adder.
//   a, b, c_in  in   operand bits and carry-in
//   sum, c_out  out  sum bit and carry-out
module fa_v1 (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// state | meaning
// IDLE  | waiting for start; sum/c_out hold the last result
// RUN   | adding one bit per edge, N edges in total
// DONE  | result just published; one-cycle done pulse
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [N-1:0]  rs;
  logic          cy;
  logic [CW-1:0] cnt;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  fa_v1 u_fa (
    .sum   (fa_sum),
    .c_out (fa_cout),
    .a     (ra[0]),
    .b     (rb[0]),
    .c_in  (cy)
  );

  assign last_bit = (cnt == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ra      <= '0;
      rb      <= '0;
      rs      <= '0;
      cy      <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            cy  <= c_in;
            cnt <= '0;
            rs  <= '0;
          end
        end
        RUN: begin
          // Each new sum bit enters at the MSB, so after N shifts the
          // first (LSB) bit has reached rs[0].
          rs  <= {fa_sum, rs[N-1:1]};
          cy  <= fa_cout;
          ra  <= {1'b0, ra[N-1:1]};
          rb  <= {1'b0, rb[N-1:1]};
          cnt <= cnt + 1'b1;
          // Publish straight from the adder output on the final bit;
          // rs itself only catches up on this same edge.
          if (last_bit) begin
            sum   <= {fa_sum, rs[N-1:1]};
            c_out <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [N-1:0] sum;
  logic         c_out;
  logic         busy;
  logic         done;

  int n_pass;
  int n_total;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one addition from IDLE: start is sampled on the next edge, then
  // wait (bounded) for done. Checks latency, busy length and busy/done overlap.
  task automatic do_op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic cv, output logic [N-1:0] s, output logic co);
    int lat;
    int busy_cnt;
    int overlap;
    a = av; b = bv; c_in = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; c_in = ~cv;
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < 3 * N) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy && done) overlap++;
    chk({name, " latency"}, lat, N);
    chk({name, " busy_cycles"}, busy_cnt, N);
    chk({name, " busy_done_overlap"}, overlap, 0);
    s = sum;
    co = c_out;
  endtask

  initial begin
    logic [N-1:0] s;
    logic         co;
    logic [N:0]   gold;
    logic [N-1:0] ra_v;
    logic [N-1:0] rb_v;
    logic         rc_v;
    int           e;
    int           ndone;
    int           done_at;
    int           last_done;
    int           bad_period;
    string        nm;

    n_pass = 0;
    n_total = 0;

    vecs[0] = '{"5A+3C",    8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{"FF+01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"FF+FF+1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"00+00",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{"00+00+1",  8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{"80+80",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{"AA+55+1",  8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{"7F+01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset held for two edges with start and operands active.
    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
    tick();
    tick();
    chk("reset sum", sum, 0);
    chk("reset c_out", c_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post-reset busy", busy, 0);
    chk("post-reset sum", sum, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, s, co);
      chk({vecs[i].name, " sum"}, s, vecs[i].exp_sum);
      chk({vecs[i].name, " c_out"}, co, vecs[i].exp_cout);
      tick();
      chk({vecs[i].name, " done_pulse_width"}, done, 0);
      chk({vecs[i].name, " sum_hold"}, sum, vecs[i].exp_sum);
    end

    // start ignored while busy; previous result (5A+3C) visible until k+N.
    do_op("pre", 8'h5A, 8'h3C, 1'b0, s, co);
    tick();
    a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
    tick();                                   // edge k
    start = 1'b0; a = 8'hF0; b = 8'h0F; c_in = 1'b1;
    tick();                                   // k+1
    tick();                                   // k+2
    start = 1'b1;
    tick();                                   // k+3, ignored
    start = 1'b0;
    chk("ignore old_sum_k3", sum, 8'h96);
    e = 3; ndone = 0; done_at = -1;
    while (e < 3 + 20) begin
      if (e == N - 1) chk("ignore old_sum_kN-1", sum, 8'h96);
      tick();
      e++;
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = e;
          chk("ignore sum", sum, 8'h03);
          chk("ignore c_out", c_out, 0);
        end
      end
    end
    chk("ignore done_count", ndone, 1);
    chk("ignore done_edge", done_at, N);

    // Reset on edge k+4 of a RUN.
    a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    tick();                                   // k
    start = 1'b0;
    tick(); tick(); tick();                   // k+1..k+3
    reset = 1'b1;
    tick();                                   // k+4
    reset = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset sum", sum, 0);
    chk("midreset c_out", c_out, 0);
    ndone = 0;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("midreset no_activity", ndone, 0);
    do_op("after_reset", 8'h12, 8'h34, 1'b1, s, co);
    chk("after_reset sum", s, 8'h47);
    chk("after_reset c_out", co, 0);
    tick();

    // Back-to-back with start held high.
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    e = 0; ndone = 0; last_done = -1; bad_period = 0;
    while (e < 45) begin
      tick();
      e++;
      if (done) begin
        ndone++;
        chk("b2b sum", sum, 8'h00);
        chk("b2b c_out", c_out, 1);
        if (last_done >= 0 && e - last_done != N + 2) bad_period++;
        if (last_done < 0) chk("b2b first_done_edge", e, N + 1);
        last_done = e;
      end
    end
    chk("b2b done_count", ndone, 4);
    chk("b2b bad_periods", bad_period, 0);
    start = 1'b0;
    repeat (2 * N) tick();

    // Random vectors against the golden model.
    for (int i = 0; i < 200; i++) begin
      ra_v = N'($urandom_range(0, (1 << N) - 1));
      rb_v = N'($urandom_range(0, (1 << N) - 1));
      rc_v = 1'($urandom_range(0, 1));
      gold = {1'b0, ra_v} + {1'b0, rb_v} + {{N{1'b0}}, rc_v};
      nm = $sformatf("rand%0d", i);
      do_op(nm, ra_v, rb_v, rc_v, s, co);
      chk({nm, " sum"}, s, gold[N-1:0]);
      chk({nm, " c_out"}, co, gold[N]);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
